// File: rtl/counter_pkg.sv
// Shared constants for the counter family: count direction and end-of-range mode.
// Divider and debouncer blocks reuse these constants.
package counter_pkg;

    // Direction encodings for the 'up' input
    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;

    // End-of-range behaviour encodings for the SATURATE parameter
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Clamp a (WIDTH+1)-bit candidate value to an inclusive maximum
    function automatic logic [31:0] clamp_max(input logic [31:0] value, input logic [31:0] max_value);
        if (value > max_value) begin
            clamp_max = max_value;
        end else begin
            clamp_max = value;
        end
    endfunction

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop: toggles on t=1, clears asynchronously while RSTN is low.
module tff_cell (
    input  logic clk,
    input  logic RSTN,
    input  logic t,
    output logic q
);

    // Toggle storage with asynchronous active-low clear
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/tff_mod_counter.sv
// Up/down modulo counter built from a bank of T flip-flop cells.
// Next-state logic picks the target value; each cell toggles where the target
// differs from the current count. Supports clear, load with clamp, enable,
// wrap or saturate at the range ends, a combinational terminal-count flag and
// a registered wrap pulse.
module tff_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 2 ** WIDTH,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             RSTN,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    // Reject moduli the counter cannot represent
    if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
        $fatal(1, "tff_mod_counter: MODULUS out of range 2..2**WIDTH");
    end

    // One extra bit so +1 at the top of the range cannot overflow into count
    localparam logic [WIDTH:0] MOD_MAX  = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ZERO_EXT = {(WIDTH + 1){1'b0}};
    localparam logic [WIDTH:0] ONE_EXT  = {{WIDTH{1'b0}}, 1'b1};
    localparam logic           SAT_MODE = SATURATE;

    logic [WIDTH:0]   count_ext_s;
    logic [WIDTH:0]   load_ext_s;
    logic [WIDTH:0]   terminal_s;
    logic [WIDTH:0]   next_ext_s;
    logic             wrap_next_s;
    logic [WIDTH-1:0] next_s;
    logic [WIDTH-1:0] t_s;
    logic [WIDTH-1:0] q_s;

    assign count_ext_s = {1'b0, count};
    assign load_ext_s  = {1'b0, load_val};
    assign terminal_s  = (up == DIR_UP) ? MOD_MAX : ZERO_EXT;

    // Target value and wrap flag for the next edge: clr > load > en > hold
    always_comb begin
        next_ext_s  = count_ext_s;
        wrap_next_s = 1'b0;
        if (clr) begin
            next_ext_s  = ZERO_EXT;
            wrap_next_s = 1'b0;
        end else if (load) begin
            next_ext_s  = (WIDTH + 1)'(clamp_max(32'(load_ext_s), 32'(MOD_MAX)));
            wrap_next_s = 1'b0;
        end else if (en) begin
            if (up == DIR_UP) begin
                if (count_ext_s == MOD_MAX) begin
                    if (SAT_MODE == MODE_SAT) begin
                        next_ext_s  = count_ext_s;
                        wrap_next_s = 1'b0;
                    end else begin
                        next_ext_s  = ZERO_EXT;
                        wrap_next_s = 1'b1;
                    end
                end else begin
                    next_ext_s  = count_ext_s + ONE_EXT;
                    wrap_next_s = 1'b0;
                end
            end else begin
                if (count_ext_s == ZERO_EXT) begin
                    if (SAT_MODE == MODE_SAT) begin
                        next_ext_s  = count_ext_s;
                        wrap_next_s = 1'b0;
                    end else begin
                        next_ext_s  = MOD_MAX;
                        wrap_next_s = 1'b1;
                    end
                end else begin
                    next_ext_s  = count_ext_s - ONE_EXT;
                    wrap_next_s = 1'b0;
                end
            end
        end else begin
            next_ext_s  = count_ext_s;
            wrap_next_s = 1'b0;
        end
    end

    // Top bit of next_ext_s is always zero: every target lies in 0..MODULUS-1
    assign next_s = next_ext_s[WIDTH-1:0];
    assign t_s    = next_s ^ count;

    // Bank of toggle cells holding the count
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk  (clk),
            .RSTN (RSTN),
            .t    (t_s[i]),
            .q    (q_s[i])
        );
    end

    assign count = q_s;

    // Terminal count depends on the present direction, no clock latency
    assign tc = en & (count_ext_s == terminal_s);

    // One-cycle wrap pulse registered after a wrap-around step
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_next_s;
        end
    end

endmodule

// File: tb/tb_tff_mod_counter.sv
// Bench for tff_mod_counter: four configurations share one stimulus stream.
//   inst 0: WIDTH=3 MODULUS=8 wrap
//   inst 1: WIDTH=3 MODULUS=6 wrap
//   inst 2: WIDTH=3 MODULUS=6 saturate
//   inst 3: WIDTH=1 MODULUS=2 wrap
// Expected results are pushed to a scoreboard when an edge is stimulated and
// popped and compared after the edge.
module tb_tff_mod_counter;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en;
    logic       up;
    logic       clr;
    logic       load;
    logic [2:0] lv;

    logic [2:0] cnt_a;
    logic [2:0] cnt_b;
    logic [2:0] cnt_c;
    logic [0:0] cnt_d;
    logic [3:0] tc_v;
    logic [3:0] wrap_v;

    typedef struct {
        int inst;
        int cnt;
        int wrp;
    } exp_t;

    exp_t sb[$];
    int   m_cnt[4];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    tff_mod_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b0)) u_a (
        .clk(clk), .RSTN(rstn), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv), .count(cnt_a), .tc(tc_v[0]), .wrap(wrap_v[0]));
    tff_mod_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(1'b0)) u_b (
        .clk(clk), .RSTN(rstn), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv), .count(cnt_b), .tc(tc_v[1]), .wrap(wrap_v[1]));
    tff_mod_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(1'b1)) u_c (
        .clk(clk), .RSTN(rstn), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv), .count(cnt_c), .tc(tc_v[2]), .wrap(wrap_v[2]));
    tff_mod_counter #(.WIDTH(1), .MODULUS(2), .SATURATE(1'b0)) u_d (
        .clk(clk), .RSTN(rstn), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv[0:0]), .count(cnt_d), .tc(tc_v[3]), .wrap(wrap_v[3]));

    function automatic int mod_of(int i);
        case (i)
            0:       mod_of = 8;
            1:       mod_of = 6;
            2:       mod_of = 6;
            default: mod_of = 2;
        endcase
    endfunction

    function automatic int sat_of(int i);
        sat_of = (i == 2) ? 1 : 0;
    endfunction

    function automatic int lv_mask(int i);
        lv_mask = (i == 3) ? 1 : 7;
    endfunction

    function automatic int obs_cnt(int i);
        case (i)
            0:       obs_cnt = int'(cnt_a);
            1:       obs_cnt = int'(cnt_b);
            2:       obs_cnt = int'(cnt_c);
            default: obs_cnt = int'(cnt_d);
        endcase
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model one edge for every instance and push its expectation
    task automatic push_expected();
        for (int i = 0; i < 4; i++) begin
            int m;
            int c;
            int w;
            int l;
            m = mod_of(i);
            c = m_cnt[i];
            w = 0;
            if (clr) begin
                c = 0;
            end else if (load) begin
                l = int'(lv) & lv_mask(i);
                c = (l >= m) ? m - 1 : l;
            end else if (en) begin
                if (up) begin
                    if (c == m - 1) begin
                        if (sat_of(i) == 0) begin
                            c = 0;
                            w = 1;
                        end
                    end else begin
                        c = c + 1;
                    end
                end else begin
                    if (c == 0) begin
                        if (sat_of(i) == 0) begin
                            c = m - 1;
                            w = 1;
                        end
                    end else begin
                        c = c - 1;
                    end
                end
            end
            m_cnt[i] = c;
            sb.push_back('{i, c, w});
        end
    endtask

    // Check tc before the edge, apply one edge, then drain the scoreboard
    task automatic step(input string tag);
        exp_t e;
        #1;
        for (int i = 0; i < 4; i++) begin
            int term;
            term = up ? mod_of(i) - 1 : 0;
            check($sformatf("%s.i%0d.tc", tag, i), int'(tc_v[i]),
                  (en && (m_cnt[i] == term)) ? 1 : 0);
        end
        push_expected();
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("%s.i%0d.count", tag, e.inst), obs_cnt(e.inst), e.cnt);
            check($sformatf("%s.i%0d.wrap", tag, e.inst), int'(wrap_v[e.inst]), e.wrp);
        end
    endtask

    task automatic set_in(input logic e_i, input logic u_i, input logic c_i,
                          input logic l_i, input logic [2:0] v_i);
        en   = e_i;
        up   = u_i;
        clr  = c_i;
        load = l_i;
        lv   = v_i;
    endtask

    initial begin
        int up_seq[9];
        up_seq = '{1, 2, 3, 4, 5, 6, 7, 0, 1};

        // Reset state
        rstn = 1'b0;
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        #12;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset.i%0d.count", i), obs_cnt(i), 0);
            check($sformatf("reset.i%0d.wrap", i), int'(wrap_v[i]), 0);
            check($sformatf("reset.i%0d.tc", i), int'(tc_v[i]), 0);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Count up from reset: mod-8 sequence 1..7,0,1
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        for (int k = 0; k < 9; k++) begin
            step($sformatf("up%0d", k));
            check($sformatf("up%0d.seq8", k), int'(cnt_a), up_seq[k]);
        end

        // Count down from 0: mod-6 goes 5,4,3,2,1,0,5
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        step("clr_a");
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int k = 0; k < 7; k++) step($sformatf("down%0d", k));

        // Saturating up then one step down
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        step("clr_b");
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        for (int k = 0; k < 8; k++) step($sformatf("sat%0d", k));
        check("sat.stick5", int'(cnt_c), 5);
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        step("sat_down");
        check("sat.down4", int'(cnt_c), 4);

        // Priority and load clamp, then hold with en=0
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 3'd5);
        step("prio_clr");
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 3'd3);
        step("prio_load3");
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 3'd7);
        step("load7");
        check("load7.clamp", int'(cnt_b), 5);
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        for (int k = 0; k < 4; k++) step($sformatf("hold%0d", k));

        // Async reset between edges with a wrap pulse pending on the 1-bit counter
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 3'd3);
        step("pre_load3");
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        step("pre_inc");
        check("pre_rst.a4", int'(cnt_a), 4);
        check("pre_rst.dwrap", int'(wrap_v[3]), 1);
        rstn = 1'b0;
        #2;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("arst.i%0d.count", i), obs_cnt(i), 0);
            check($sformatf("arst.i%0d.wrap", i), int'(wrap_v[i]), 0);
            m_cnt[i] = 0;
        end
        #1;
        rstn = 1'b1;
        step("post_rst");
        check("post_rst.a1", int'(cnt_a), 1);

        // Mixed random traffic against the model
        for (int k = 0; k < 40; k++) begin
            set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 7) == 0),
                   3'($urandom_range(0, 7)));
            step($sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
